// File: rtl/memory_stage_pkg.sv
// Shared types for the memory stage: operation codes, data-bus request and
// response records, the E/M and M/W pipeline records, and the op
// classification helpers used by the stage and its alignment unit.
package memory_stage_pkg;

  typedef logic [63:0] word_t;
  typedef logic [63:0] addr_t;
  typedef logic [4:0]  creg_addr_t;

  typedef enum logic [4:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR,
    OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
    OP_SB, OP_SH, OP_SW, OP_SD
  } op_t;

  typedef struct packed {
    op_t  op;
    logic regWrite;
  } control_t;

  // Log2 of the access width in bytes.
  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef logic [7:0] strobe_t;

  typedef enum logic {
    MEM_IDLE,
    MEM_REQ
  } mem_state_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef struct packed {
    word_t      pc;
    control_t   ctl;
    creg_addr_t dst;
    word_t      result;
    addr_t      memory_address;
    logic       is_bubble;
  } execute_data_t;

  typedef struct packed {
    word_t      pc;
    control_t   ctl;
    creg_addr_t dst;
    word_t      result;
    logic       is_bubble;
    addr_t      mem_addr;
  } memory_data_t;

  function automatic logic is_load(input op_t op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU};
  endfunction

  function automatic logic is_store(input op_t op);
    return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
  endfunction

  function automatic logic is_mem_op(input op_t op);
    return is_load(op) || is_store(op);
  endfunction

endpackage

// File: rtl/memory_stage_align.sv
// mem_align: combinational byte-lane alignment for the data bus.
//   op           : memory operation being issued
//   addrLow      : byte offset of the access within the doubleword
//   wdata        : store source value (rs2)
//   rdata        : doubleword returned by the bus
//   size         : access size encoding for the request
//   strobe       : byte-enable mask (zero for loads)
//   wdataShifted : store data placed on its byte lanes (zero for loads)
//   rdataExt     : load value moved to bit 0 and sign/zero extended
module mem_align
  import memory_stage_pkg::*;
(
  input  op_t        op,
  input  logic [2:0] addrLow,
  input  word_t      wdata,
  input  word_t      rdata,
  output msize_t     size,
  output strobe_t    strobe,
  output word_t      wdataShifted,
  output word_t      rdataExt
);

  logic [5:0] bitOffset;
  strobe_t    baseMask;
  word_t      rdataShifted;

  logic signed [7:0]  loadByte;
  logic signed [15:0] loadHalf;
  logic signed [31:0] loadWord;

  assign bitOffset = {addrLow, 3'b000};

  always_comb begin
    size     = MSIZE8;
    baseMask = 8'hFF;
    case (op)
      OP_LB, OP_LBU, OP_SB: begin
        size     = MSIZE1;
        baseMask = 8'h01;
      end
      OP_LH, OP_LHU, OP_SH: begin
        size     = MSIZE2;
        baseMask = 8'h03;
      end
      OP_LW, OP_LWU, OP_SW: begin
        size     = MSIZE4;
        baseMask = 8'h0F;
      end
      default: ;
    endcase
  end

  // Lanes shifted past bit 63 / strobe bit 7 fall off; alignment is assumed.
  assign strobe       = is_store(op) ? (baseMask << addrLow) : 8'h00;
  assign wdataShifted = is_store(op) ? (wdata << bitOffset) : '0;

  assign rdataShifted = rdata >> bitOffset;
  assign loadByte     = rdataShifted[7:0];
  assign loadHalf     = rdataShifted[15:0];
  assign loadWord     = rdataShifted[31:0];

  always_comb begin
    rdataExt = '0;
    case (op)
      OP_LB:   rdataExt = {{56{loadByte[7]}}, loadByte};
      OP_LH:   rdataExt = {{48{loadHalf[15]}}, loadHalf};
      OP_LW:   rdataExt = {{32{loadWord[31]}}, loadWord};
      OP_LBU:  rdataExt = {56'd0, rdataShifted[7:0]};
      OP_LHU:  rdataExt = {48'd0, rdataShifted[15:0]};
      OP_LWU:  rdataExt = {32'd0, rdataShifted[31:0]};
      OP_LD:   rdataExt = rdataShifted;
      default: rdataExt = '0;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: pipeline memory stage and owner of the M/W register.
//   clk    : system clock
//   reset  : synchronous, active-high
//   dataE  : record from the execute stage (stores carry rs2 in result)
//   dreq   : data-bus request, driven solely from the request registers
//   dresp  : data-bus response; data is taken only when data_ok is high
//   dataM  : registered record for writeback
//   stallM : upstream must hold dataE while high
// Non-memory ops pass through in one cycle. A memory op is captured in IDLE,
// its request is held in REQ until data_ok, and the result lands in dataM
// on the following edge.
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  output memory_data_t  dataM,
  output logic          stallM
);

  mem_state_t state, stateNext;

  word_t      reqPc_p1;
  control_t   reqCtl_p1;
  creg_addr_t reqDst_p1;
  addr_t      reqAddr_p1;
  word_t      reqWdata_p1;
  logic       vld_p1;

  logic    isMemOp;
  msize_t  alignSize;
  strobe_t alignStrobe;
  word_t   alignWdata;
  word_t   loadData;

  // Handshake acceptance is judged on data_ok alone.
  logic unusedAddrOk;
  assign unusedAddrOk = dresp.addr_ok;

  assign isMemOp = !dataE.is_bubble && is_mem_op(dataE.ctl.op);
  assign vld_p1  = (state == MEM_REQ);

  mem_align uAlign (
    .op           (reqCtl_p1.op),
    .addrLow      (reqAddr_p1[2:0]),
    .wdata        (reqWdata_p1),
    .rdata        (dresp.data),
    .size         (alignSize),
    .strobe       (alignStrobe),
    .wdataShifted (alignWdata),
    .rdataExt     (loadData)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MEM_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    stallM    = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (isMemOp) begin
          stallM    = 1'b1;
          stateNext = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (dresp.data_ok) begin
          stateNext = MEM_IDLE;
        end else begin
          stallM = 1'b1;
        end
      end
      default: stateNext = MEM_IDLE;
    endcase
  end

  always_comb begin
    dreq.valid  = vld_p1;
    dreq.addr   = reqAddr_p1;
    dreq.size   = alignSize;
    dreq.strobe = alignStrobe;
    dreq.data   = alignWdata;
  end

  // ---- E/M boundary: request registers, loaded only when an op is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      reqPc_p1    <= '0;
      reqCtl_p1   <= '0;
      reqDst_p1   <= '0;
      reqAddr_p1  <= '0;
      reqWdata_p1 <= '0;
    end else if (state == MEM_IDLE && isMemOp) begin
      reqPc_p1    <= dataE.pc;
      reqCtl_p1   <= dataE.ctl;
      reqDst_p1   <= dataE.dst;
      reqAddr_p1  <= dataE.memory_address;
      reqWdata_p1 <= dataE.result;
    end
  end

  // ---- M/W boundary: bubble while a request is outstanding
  always_ff @(posedge clk) begin
    if (reset) begin
      dataM           <= '0;
      dataM.is_bubble <= 1'b1;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (isMemOp) begin
            dataM           <= '0;
            dataM.is_bubble <= 1'b1;
          end else begin
            dataM.pc        <= dataE.pc;
            dataM.ctl       <= dataE.ctl;
            dataM.dst       <= dataE.dst;
            dataM.result    <= dataE.result;
            dataM.is_bubble <= dataE.is_bubble;
            dataM.mem_addr  <= '0;
          end
        end
        MEM_REQ: begin
          if (dresp.data_ok) begin
            dataM.pc        <= reqPc_p1;
            dataM.ctl       <= reqCtl_p1;
            dataM.dst       <= reqDst_p1;
            dataM.result    <= is_load(reqCtl_p1.op) ? loadData : '0;
            dataM.is_bubble <= 1'b0;
            dataM.mem_addr  <= reqAddr_p1;
          end else begin
            dataM           <= '0;
            dataM.is_bubble <= 1'b1;
          end
        end
        default: begin
          dataM           <= '0;
          dataM.is_bubble <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  execute_data_t dataE;
  dbus_req_t     dreq;
  dbus_resp_t    dresp;
  memory_data_t  dataM;
  logic          stallM;

  int checks = 0;
  int errors = 0;

  memory_stage dut (
    .clk    (clk),
    .reset  (reset),
    .dataE  (dataE),
    .dreq   (dreq),
    .dresp  (dresp),
    .dataM  (dataM),
    .stallM (stallM)
  );

  always #5 clk = ~clk;

  op_t memOps[11] = '{OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
                      OP_SB, OP_SH, OP_SW, OP_SD};
  op_t aluOps[5]  = '{OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model: access rules expressed in bytes
  function automatic int accessBytes(input op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_LWU, OP_SW: return 4;
      default:              return 8;
    endcase
  endfunction

  function automatic bit modelIsStore(input op_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SD);
  endfunction

  function automatic bit modelIsSigned(input op_t op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
  endfunction

  function automatic logic [7:0] modelStrobe(input op_t op, input logic [63:0] addr);
    int n   = accessBytes(op);
    int off = int'(addr[2:0]);
    logic [15:0] m = ((16'd1 << n) - 16'd1) << off;
    return modelIsStore(op) ? m[7:0] : 8'h00;
  endfunction

  function automatic logic [63:0] modelLoad(input op_t op, input logic [63:0] addr,
                                            input logic [63:0] rdata);
    int n = accessBytes(op);
    logic [63:0] v = rdata >> (8 * int'(addr[2:0]));
    logic [63:0] mask;
    if (modelIsStore(op)) return 64'd0;
    if (n < 8) begin
      mask = (64'd1 << (8 * n)) - 64'd1;
      v    = v & mask;
      if (modelIsSigned(op) && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic setBubble();
    dataE           = '0;
    dataE.is_bubble = 1'b1;
  endtask

  // Non-memory op (or any bubble): one-cycle pass-through, no bus traffic.
  task automatic doNonMem(input op_t op, input logic [63:0] res, input bit bub);
    logic [63:0] pc  = rnd64();
    logic [4:0]  dst = 5'($urandom);
    dataE.pc             = pc;
    dataE.ctl.op         = op;
    dataE.ctl.regWrite   = 1'($urandom);
    dataE.dst            = dst;
    dataE.result         = res;
    dataE.memory_address = rnd64();
    dataE.is_bubble      = bub;
    @(negedge clk);
    check("nm_stall", 64'(stallM), 64'd0);
    check("nm_valid", 64'(dreq.valid), 64'd0);
    @(posedge clk); #1;
    check("nm_bubble", 64'(dataM.is_bubble), 64'(bub));
    check("nm_memaddr", dataM.mem_addr, 64'd0);
    if (!bub) begin
      check("nm_result", dataM.result, res);
      check("nm_pc", dataM.pc, pc);
      check("nm_dst", 64'(dataM.dst), 64'(dst));
      check("nm_op", 64'(dataM.ctl.op), 64'(op));
    end
  endtask

  // Memory op with 'waits' cycles of data_ok=0 before the completing cycle.
  task automatic doMem(input op_t op, input logic [63:0] addr, input logic [63:0] rs2,
                       input logic [63:0] rdata, input int waits);
    logic [63:0] pc  = rnd64();
    logic [4:0]  dst = 5'($urandom);
    int n = accessBytes(op);
    dataE.pc             = pc;
    dataE.ctl.op         = op;
    dataE.ctl.regWrite   = 1'($urandom);
    dataE.dst            = dst;
    dataE.result         = rs2;
    dataE.memory_address = addr;
    dataE.is_bubble      = 1'b0;
    dresp.data_ok        = 1'b0;
    @(negedge clk);
    check("mem_accept_stall", 64'(stallM), 64'd1);
    check("mem_accept_valid", 64'(dreq.valid), 64'd0);
    @(posedge clk); #1;
    check("mem_req_bubble", 64'(dataM.is_bubble), 64'd1);
    for (int i = 0; i <= waits; i++) begin
      dresp.addr_ok = 1'($urandom);
      if (i == waits) begin
        dresp.data_ok = 1'b1;
        dresp.data    = rdata;
      end else begin
        dresp.data_ok = 1'b0;
        dresp.data    = rnd64();
      end
      // request must ignore upstream changes while outstanding
      dataE.memory_address = rnd64();
      dataE.result         = rnd64();
      @(negedge clk);
      check("req_valid", 64'(dreq.valid), 64'd1);
      check("req_addr", dreq.addr, addr);
      check("req_size", 64'(dreq.size), 64'($clog2(n)));
      check("req_strobe", 64'(dreq.strobe), 64'(modelStrobe(op, addr)));
      if (modelIsStore(op))
        check("req_data", dreq.data, rs2 << (8 * int'(addr[2:0])));
      check("req_stall", 64'(stallM), 64'(i != waits));
      @(posedge clk); #1;
      if (i != waits) check("req_wait_bubble", 64'(dataM.is_bubble), 64'd1);
    end
    dresp.data_ok = 1'b0;
    check("done_valid", 64'(dreq.valid), 64'd0);
    check("done_bubble", 64'(dataM.is_bubble), 64'd0);
    check("done_result", dataM.result, modelLoad(op, addr, rdata));
    check("done_pc", dataM.pc, pc);
    check("done_dst", 64'(dataM.dst), 64'(dst));
    check("done_op", 64'(dataM.ctl.op), 64'(op));
    check("done_memaddr", dataM.mem_addr, addr);
  endtask

  initial begin
    logic [63:0] base;
    logic [63:0] addr;
    op_t op;
    int n;

    reset = 1'b1;
    dresp = '0;
    setBubble();
    repeat (3) @(posedge clk);
    #1;
    check("rst_bubble", 64'(dataM.is_bubble), 64'd1);
    check("rst_result", dataM.result, 64'd0);
    check("rst_pc", dataM.pc, 64'd0);
    check("rst_memaddr", dataM.mem_addr, 64'd0);
    @(negedge clk);
    check("rst_valid", 64'(dreq.valid), 64'd0);
    check("rst_stall", 64'(stallM), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    doNonMem(OP_ADD, 64'h5, 1'b0);
    check("add_const", dataM.result, 64'h5);

    doMem(OP_SB, 64'h8000_0003, 64'hAB, rnd64(), 2);
    check("sb_const", dataM.result, 64'd0);

    doMem(OP_LB, 64'h8000_0006, 64'h12, 64'h0080_0000_0000_0000, 3);
    check("lb_const", dataM.result, 64'hFFFF_FFFF_FFFF_FF80);
    doMem(OP_LBU, 64'h8000_0006, 64'h12, 64'h0080_0000_0000_0000, 3);
    check("lbu_const", dataM.result, 64'h80);

    doMem(OP_LW, 64'h8000_0004, 64'h0, 64'h8000_0001_1234_5678, 1);
    check("lw_const", dataM.result, 64'hFFFF_FFFF_8000_0001);
    doMem(OP_LD, 64'h8000_0008, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 0);
    check("ld_const", dataM.result, 64'hDEAD_BEEF_CAFE_F00D);

    doMem(OP_SD, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, rnd64(), 0);
    doMem(OP_LD, 64'h8000_0010, 64'h0, 64'h0123_4567_89AB_CDEF, 0);

    doNonMem(OP_LW, 64'h77, 1'b1);

    // reset while a request is outstanding, then a stray data_ok
    dataE.pc             = rnd64();
    dataE.ctl.op         = OP_LW;
    dataE.ctl.regWrite   = 1'b1;
    dataE.dst            = 5'd3;
    dataE.result         = 64'd0;
    dataE.memory_address = 64'h8000_0020;
    dataE.is_bubble      = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rreq_valid", 64'(dreq.valid), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    setBubble();
    @(posedge clk); #1;
    reset = 1'b0;
    check("rreq_valid_after", 64'(dreq.valid), 64'd0);
    check("rreq_bubble", 64'(dataM.is_bubble), 64'd1);
    dresp.data_ok = 1'b1;
    dresp.data    = rnd64();
    @(negedge clk);
    check("late_ok_valid", 64'(dreq.valid), 64'd0);
    check("late_ok_stall", 64'(stallM), 64'd0);
    @(posedge clk); #1;
    dresp.data_ok = 1'b0;
    check("late_ok_bubble", 64'(dataM.is_bubble), 64'd1);
    check("late_ok_memaddr", dataM.mem_addr, 64'd0);
    check("late_ok_valid2", 64'(dreq.valid), 64'd0);

    for (int t = 0; t < 60; t++) begin
      int kind = $urandom_range(0, 9);
      if (kind < 3) begin
        doNonMem(aluOps[$urandom_range(0, 4)], rnd64(), 1'b0);
      end else if (kind == 3) begin
        doNonMem(memOps[$urandom_range(0, 10)], rnd64(), 1'b1);
      end else begin
        op   = memOps[$urandom_range(0, 10)];
        n    = accessBytes(op);
        base = rnd64() & ~64'h7;
        addr = base | 64'($urandom_range(0, 8 / n - 1) * n);
        doMem(op, addr, rnd64(), rnd64(), $urandom_range(0, 3));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline memory stage: consumes `execute_data_t` from the execute stage, performs loads and stores on the data bus, and produces registered `memory_data_t` for writeback. Non-memory ops pass through with one cycle of latency. Memory ops hold a bus request until `data_ok` while stalling upstream. This block owns the M/W pipeline register.

## Interface
- No parameters; all widths come from `common` (64-bit `word_t`, 64-bit address).
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high.
- `dataE`  in  `execute_data_t`  pc, ctl (op), dst, result, memory_address, is_bubble; for stores, `result` carries the rs2 value.
- `dreq`  out  `dbus_req_t`  valid, addr, size, strobe, data.
- `dresp`  in  `dbus_resp_t`  addr_ok, data_ok, data (64-bit, doubleword-aligned lane).
- `dataM`  out  `memory_data_t`  registered: pc, ctl, dst, result, is_bubble, mem_addr.
- `stallM`  out  1  upstream must hold `dataE` while high.

## Operation
- Memory op: `dataE.is_bubble==0` and op ∈ {LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD}.
- FSM states: IDLE, REQ.
  - IDLE + memory op: capture op, addr, store data, pc, dst and ctl into request regs; go to REQ. `stallM=1` combinationally in this cycle.
  - IDLE + other op: no bus activity; `stallM=0`.
  - REQ: `dreq.valid=1`, driven only from request regs, and held until `data_ok`. `addr_ok` is ignored.
    - `data_ok=0`: stay in REQ, `stallM=1`.
    - `data_ok=1`: `stallM=0`, go to IDLE.
- Size encoding: B→MSIZE1, H→MSIZE2, W→MSIZE4, D→MSIZE8.
- `dreq.addr`: the full `memory_address`.
- `dreq.strobe` (stores only): base mask 0x01/0x03/0x0F/0xFF, shifted left by addr[2:0]. Loads drive strobe = 0.
- `dreq.data` (stores): rs2 shifted left by 8×addr[2:0]. Bits above 64 are dropped.
- Load result: `dresp.data >> (8×addr[2:0])`, truncated to the access size.
  - LB/LH/LW sign-extend to 64 bits.
  - LBU/LHU/LWU zero-extend.
  - LD uses the value as-is.
- Stores: `dataM.result` = 0. Non-memory ops: `dataM.result = dataE.result`.
- Natural alignment of the access is a precondition. Misaligned accesses are not detected or trapped.
- `dataM.mem_addr` = access address for memory ops, 0 otherwise (used for commit trace).

## Timing
- Reset: state=IDLE, `dreq.valid=0`, all request regs 0, `dataM` all-zero with `is_bubble=1`, `stallM=0`.
- Non-memory op at edge-cycle t → on `dataM` at t+1.
- Memory op presented at t:
  - `dreq.valid` rises at t+1.
  - `data_ok` at cycle k ≥ t+1 → `dataM` holds the result at k+1; `dreq.valid=0` at k+1.
  - Minimum latency 2 cycles.
  - `dataM.is_bubble=1` for cycles t+1..k.
- `data_ok` in the same cycle `valid` first rises is legal and completes that cycle.
- `dreq` fields must not change while in REQ, even if `dataE` changes.
- Back-to-back memory ops: the next op is accepted in IDLE at k+1. Its `valid` rises at k+2, so `valid` drops for one cycle.
- Bubble input in IDLE: `dataM.is_bubble=1` next cycle.
- Reset asserted in REQ: next cycle is IDLE with `valid=0`. The in-flight response is dropped, and a late `data_ok` while IDLE is ignored.
- `dresp.data` is sampled only in the cycle where `data_ok=1`.

## Structure
- `common`: `msize_t`, `strobe_t`, `dbus_req_t`, `dbus_resp_t`, `memory_data_t`, and `is_load`/`is_store` op-classification functions.
- One combinational sub-module, `mem_align`, holds the alignment/extension logic: (op, addr[2:0], wdata, rdata) → (size, strobe, shifted wdata, extended rdata).
- `memory_stage` contains the FSM, the request registers and the `dataM` register.

## Test plan
- Reset, then ADD with result 0x5 → `dataM.result`=0x5 one cycle later; `dreq.valid` never asserted; `stallM=0` throughout.
- SB with addr 0x80000003, rs2=0xAB → `dreq` size=MSIZE1, strobe=0x08, data[31:24]=0xAB; `stallM=1` until `data_ok`; `dataM.result`=0.
- LB at addr 0x80000006, `dresp.data`=0x0080_0000_0000_0000, `data_ok` after 3 wait cycles → `dataM.result`=0xFFFF_FFFF_FFFF_FF80; `valid` held stable for all 4 REQ cycles. Same access with LBU → 0x80.
- LW at addr 0x80000004 with data[63:32]=0x8000_0001 → result 0xFFFF_FFFF_8000_0001. LD at 0x80000008 → the full 64-bit data word unchanged.
- Back-to-back SD then LD with immediate `data_ok` → each completes with 2-cycle latency and one idle cycle between `valid` pulses.
- Reset asserted during REQ, then `data_ok` the cycle after → `valid=0`, `dataM` is a bubble, and no result is written.
